// File: rtl/noc_sequencer_if.sv
// Control/status bundle between a host and the NoC run sequencer.
// master: the host side (drives controls, observes ops/status).
// slave:  the sequencer side.
interface noc_sequencer_if #(
  parameter int unsigned NUM_ROUTERS = 16,
  parameter int unsigned ROUTER_BITS = 4,
  parameter int unsigned OP_BITS     = 4,
  parameter int unsigned CYCLE_BITS  = 16,
  parameter int unsigned FILL_BITS   = 6
);
  logic                           start;
  logic                           abort;
  logic                           stall;
  logic [CYCLE_BITS-1:0]          max_cycle;
  logic [NUM_ROUTERS-1:0]         rt_valid;
  logic [NUM_ROUTERS-1:0]         fill_pending;
  logic [NUM_ROUTERS-1:0]         inject_ok;
  logic [NUM_ROUTERS-1:0]         router_done;
  logic [NUM_ROUTERS-1:0]         traffic_empty;
  logic [NUM_ROUTERS*OP_BITS-1:0] router_op;
  logic [NUM_ROUTERS*OP_BITS-1:0] traffic_op;
  logic [ROUTER_BITS-1:0]         rt_dst;
  logic [FILL_BITS-1:0]           fill_idx;
  logic [CYCLE_BITS-1:0]          in_cycle;
  logic                           busy;
  logic                           finished;
  logic [1:0]                     done_reason;

  modport master (
    output start, abort, stall, max_cycle, rt_valid, fill_pending, inject_ok, router_done,
           traffic_empty,
    input  router_op, traffic_op, rt_dst, fill_idx, in_cycle, busy, finished, done_reason
  );

  modport slave (
    input  start, abort, stall, max_cycle, rt_valid, fill_pending, inject_ok, router_done,
           traffic_empty,
    output router_op, traffic_op, rt_dst, fill_idx, in_cycle, busy, finished, done_reason
  );
endinterface

// File: rtl/noc_sequencer.sv
// NoC run controller: init, routing-table load, traffic init/fill, then repeated
// LoadStaging/Phase0/Phase1 cycles until the cycle budget or global quiescence.
module noc_sequencer #(
  parameter int unsigned NUM_ROUTERS = 16,
  parameter int unsigned ROUTER_BITS = 4,
  parameter int unsigned OP_BITS     = 4,
  parameter int unsigned CYCLE_BITS  = 16,
  parameter int unsigned FILL_DEPTH  = 64,
  parameter int unsigned FILL_BITS   = 6
) (
  input logic            clk,
  input logic            rst_n,
  noc_sequencer_if.slave bus
);

  localparam logic [OP_BITS-1:0] OpNop         = OP_BITS'(0);
  localparam logic [OP_BITS-1:0] OpInit        = OP_BITS'(1);
  localparam logic [OP_BITS-1:0] OpLoadRt      = OP_BITS'(2);
  localparam logic [OP_BITS-1:0] OpLoadStaging = OP_BITS'(3);
  localparam logic [OP_BITS-1:0] OpPhase0      = OP_BITS'(4);
  localparam logic [OP_BITS-1:0] OpPhase1      = OP_BITS'(5);
  localparam logic [OP_BITS-1:0] OpFill        = OP_BITS'(6);
  localparam logic [OP_BITS-1:0] OpDequeue     = OP_BITS'(7);

  typedef enum logic [3:0] {
    StIdle, StInit, StLoadRt, StInitTraffic, StFill, StLoadStaging, StPhase0, StPhase1, StDone
  } state_e;

  state_e                 state_q, state_d;
  logic [ROUTER_BITS-1:0] rt_dst_q, rt_dst_d;
  logic [FILL_BITS-1:0]   fill_idx_q, fill_idx_d;
  logic [CYCLE_BITS-1:0]  in_cycle_q, in_cycle_d;
  logic [CYCLE_BITS-1:0]  max_cycle_q, max_cycle_d;
  logic [1:0]             done_reason_q, done_reason_d;

  logic [NUM_ROUTERS*OP_BITS-1:0] router_op, traffic_op;
  logic [CYCLE_BITS:0]            cycle_inc;

  // One bit wider so the budget compare cannot alias when in_cycle is all ones.
  assign cycle_inc = {1'b0, in_cycle_q} + (CYCLE_BITS + 1)'(1);

  // Next-state and counter updates; abort beats stall, stall beats everything else.
  always_comb begin
    state_d       = state_q;
    rt_dst_d      = rt_dst_q;
    fill_idx_d    = fill_idx_q;
    in_cycle_d    = in_cycle_q;
    max_cycle_d   = max_cycle_q;
    done_reason_d = done_reason_q;
    if (bus.abort) begin
      state_d       = StIdle;
      done_reason_d = 2'd0;
    end else if (!bus.stall) begin
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            state_d       = StInit;
            max_cycle_d   = bus.max_cycle;
            rt_dst_d      = '0;
            fill_idx_d    = '0;
            in_cycle_d    = '0;
            done_reason_d = 2'd0;
          end
        end
        StInit: state_d = StLoadRt;
        StLoadRt: begin
          if (rt_dst_q == ROUTER_BITS'(NUM_ROUTERS - 1)) state_d = StInitTraffic;
          else rt_dst_d = rt_dst_q + ROUTER_BITS'(1);
        end
        StInitTraffic: state_d = StFill;
        StFill: begin
          if (bus.fill_pending == '0) begin
            state_d = StLoadStaging;
          end else if (fill_idx_q == FILL_BITS'(FILL_DEPTH - 1)) begin
            state_d       = StDone;
            done_reason_d = 2'd3;
          end else begin
            fill_idx_d = fill_idx_q + FILL_BITS'(1);
          end
        end
        StLoadStaging: state_d = StPhase0;
        StPhase0:      state_d = StPhase1;
        StPhase1: begin
          if (in_cycle_q != '1) in_cycle_d = cycle_inc[CYCLE_BITS-1:0];
          if (max_cycle_q != '0 && cycle_inc == {1'b0, max_cycle_q}) begin
            state_d       = StDone;
            done_reason_d = 2'd1;
          end else if (&bus.router_done && &bus.traffic_empty) begin
            state_d       = StDone;
            done_reason_d = 2'd2;
          end else begin
            state_d = StLoadStaging;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      rt_dst_q      <= '0;
      fill_idx_q    <= '0;
      in_cycle_q    <= '0;
      max_cycle_q   <= '0;
      done_reason_q <= 2'd0;
    end else begin
      state_q       <= state_d;
      rt_dst_q      <= rt_dst_d;
      fill_idx_q    <= fill_idx_d;
      in_cycle_q    <= in_cycle_d;
      max_cycle_q   <= max_cycle_d;
      done_reason_q <= done_reason_d;
    end
  end

  // Per-slice op decode from the registered state, gated by stall and per-router qualifiers.
  always_comb begin
    router_op  = '0;
    traffic_op = '0;
    if (!bus.stall) begin
      for (int unsigned i = 0; i < NUM_ROUTERS; i++) begin
        unique case (state_q)
          StInit:        router_op[i*OP_BITS +: OP_BITS] = OpInit;
          StLoadRt:      router_op[i*OP_BITS +: OP_BITS] = bus.rt_valid[i] ? OpLoadRt : OpNop;
          StInitTraffic: traffic_op[i*OP_BITS +: OP_BITS] = OpInit;
          StFill:        traffic_op[i*OP_BITS +: OP_BITS] = bus.fill_pending[i] ? OpFill : OpNop;
          StLoadStaging: begin
            router_op[i*OP_BITS +: OP_BITS]  = OpLoadStaging;
            traffic_op[i*OP_BITS +: OP_BITS] = bus.inject_ok[i] ? OpDequeue : OpNop;
          end
          StPhase0:      router_op[i*OP_BITS +: OP_BITS] = OpPhase0;
          StPhase1:      router_op[i*OP_BITS +: OP_BITS] = OpPhase1;
          default:       ;
        endcase
      end
    end
  end

  assign bus.router_op   = router_op;
  assign bus.traffic_op  = traffic_op;
  assign bus.rt_dst      = rt_dst_q;
  assign bus.fill_idx    = fill_idx_q;
  assign bus.in_cycle    = in_cycle_q;
  assign bus.busy        = (state_q != StIdle) && (state_q != StDone);
  assign bus.finished    = (state_q == StDone);
  assign bus.done_reason = done_reason_q;

endmodule

// File: tb/tb_noc_sequencer.sv
// Bench for noc_sequencer: directed scenarios plus randomized runs, every cycle
// compared against a step-level reference model of the run sequence.
module tb_noc_sequencer;
  localparam int NR = 4;
  localparam int RB = 2;
  localparam int OB = 4;
  localparam int CB = 8;
  localparam int FD = 8;
  localparam int FB = 3;
  localparam int CMAX = 255;

  localparam int S_IDLE = 0, S_INIT = 1, S_LRT = 2, S_ITR = 3, S_FILL = 4;
  localparam int S_LS = 5, S_P0 = 6, S_P1 = 7, S_DONE = 8;

  logic clk;
  logic rst_n;

  noc_sequencer_if #(.NUM_ROUTERS(NR), .ROUTER_BITS(RB), .OP_BITS(OB), .CYCLE_BITS(CB),
                     .FILL_BITS(FB)) bus ();

  noc_sequencer #(.NUM_ROUTERS(NR), .ROUTER_BITS(RB), .OP_BITS(OB), .CYCLE_BITS(CB),
                  .FILL_DEPTH(FD), .FILL_BITS(FB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model of where the run is
  int m_step, m_rt, m_fill, m_cyc, m_max, m_reason;
  // stimulus bookkeeping
  int fill_seen, p1_seen, run_len;
  int rtv_mode, fill_n, fill_pat, quiet_at, stall_pct, abort_pct, abort_at_p1;
  int stall_cnt, stall_cyc;
  bit chk_ls, chk_init, stall_arm, rnd;
  // op event counters taken from the DUT outputs
  int cnt_init, cnt_ls, cnt_fill0;
  int cnt_lrt [NR];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_step = S_IDLE; m_rt = 0; m_fill = 0; m_cyc = 0; m_max = 0; m_reason = 0;
  endtask

  // advance the model by one clock using the inputs the DUT sees at this edge
  task automatic model_step();
    int nxt;
    if (!rst_n) begin model_reset(); return; end
    if (bus.abort) begin m_step = S_IDLE; m_reason = 0; return; end
    if (bus.stall) return;
    case (m_step)
      S_IDLE, S_DONE: if (bus.start) begin
        m_step = S_INIT; m_max = int'(bus.max_cycle);
        m_rt = 0; m_fill = 0; m_cyc = 0; m_reason = 0;
      end
      S_INIT: m_step = S_LRT;
      S_LRT:  if (m_rt == NR - 1) m_step = S_ITR; else m_rt++;
      S_ITR:  m_step = S_FILL;
      S_FILL: begin
        fill_seen++;
        if (bus.fill_pending == 4'b0) m_step = S_LS;
        else if (m_fill == FD - 1) begin m_step = S_DONE; m_reason = 3; end
        else m_fill++;
      end
      S_LS: m_step = S_P0;
      S_P0: m_step = S_P1;
      S_P1: begin
        p1_seen++;
        nxt = m_cyc + 1;
        if (m_max != 0 && nxt == m_max) begin m_step = S_DONE; m_reason = 1; end
        else if (bus.router_done == 4'hf && bus.traffic_empty == 4'hf) begin
          m_step = S_DONE; m_reason = 2;
        end else m_step = S_LS;
        m_cyc = (nxt > CMAX) ? CMAX : nxt;
      end
      default: ;
    endcase
  endtask

  // per-cycle comparison of every output against the model
  task automatic compare_model();
    logic [NR*OB-1:0] er, et;
    er = '0;
    et = '0;
    if (!bus.stall) begin
      for (int i = 0; i < NR; i++) begin
        case (m_step)
          S_INIT: er[i*OB +: OB] = 4'd1;
          S_LRT:  if (bus.rt_valid[i]) er[i*OB +: OB] = 4'd2;
          S_ITR:  et[i*OB +: OB] = 4'd1;
          S_FILL: if (bus.fill_pending[i]) et[i*OB +: OB] = 4'd6;
          S_LS: begin
            er[i*OB +: OB] = 4'd3;
            if (bus.inject_ok[i]) et[i*OB +: OB] = 4'd7;
          end
          S_P0: er[i*OB +: OB] = 4'd4;
          S_P1: er[i*OB +: OB] = 4'd5;
          default: ;
        endcase
      end
    end
    check("router_op", 32'(bus.router_op), 32'(er));
    check("traffic_op", 32'(bus.traffic_op), 32'(et));
    check("rt_dst", 32'(bus.rt_dst), m_rt);
    check("fill_idx", 32'(bus.fill_idx), m_fill);
    check("in_cycle", 32'(bus.in_cycle), m_cyc);
    check("busy", 32'(bus.busy), (m_step != S_IDLE && m_step != S_DONE) ? 1 : 0);
    check("finished", 32'(bus.finished), (m_step == S_DONE) ? 1 : 0);
    check("done_reason", 32'(bus.done_reason), m_reason);
    if (bus.router_op[3:0] == 4'd1) cnt_init++;
    if (bus.router_op[3:0] == 4'd3) cnt_ls++;
    if (bus.traffic_op[3:0] == 4'd6) cnt_fill0++;
    for (int i = 0; i < NR; i++) if (bus.router_op[i*OB +: OB] == 4'd2) cnt_lrt[i]++;
  endtask

  task automatic sample();
    @(negedge clk);
    compare_model();
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.abort = 1'b0; bus.stall = 1'b0;
  endtask

  // choose inputs for the coming cycle from the scenario knobs and the model's position
  task automatic drive();
    bus.rt_valid  = (rtv_mode < 0) ? 4'($urandom) : 4'(rtv_mode);
    bus.inject_ok = (chk_ls && m_step == S_LS) ? 4'b0101 : 4'($urandom);
    bus.max_cycle = 8'($urandom);
    if (m_step == S_FILL) bus.fill_pending = (fill_seen < fill_n) ? 4'(fill_pat) : 4'b0;
    else bus.fill_pending = 4'($urandom);
    bus.router_done   = 4'($urandom);
    bus.traffic_empty = 4'($urandom);
    if (quiet_at > 0) begin
      if (m_step == S_P1 && p1_seen == quiet_at - 1) begin
        bus.router_done = 4'hf; bus.traffic_empty = 4'hf;
      end else bus.traffic_empty[0] = 1'b0;
    end else if (quiet_at == 0) begin
      bus.traffic_empty[0] = 1'b0;
    end else if ($urandom_range(0, 3) == 0) begin
      bus.router_done = 4'hf; bus.traffic_empty = 4'hf;
    end
    bus.stall = ($urandom_range(0, 99) < stall_pct);
    bus.abort = ($urandom_range(0, 99) < abort_pct);
    if (abort_at_p1 > 0 && p1_seen >= abort_at_p1) bus.abort = 1'b1;
    if (stall_arm && m_step == S_P0 && stall_cnt < 3) begin
      if (stall_cnt == 0) stall_cyc = m_cyc;
      bus.stall = 1'b1;
      stall_cnt++;
    end
    bus.start = rnd && ($urandom_range(0, 19) == 0);
  endtask

  task automatic run(input int mx, input int budget, input bit stop_lrt2);
    int n;
    fill_seen = 0; p1_seen = 0; stall_cnt = 0;
    drive();
    bus.start = 1'b1; bus.stall = 1'b0; bus.abort = 1'b0; bus.max_cycle = 8'(mx);
    sample();
    edge_step();
    n = 1;
    while (!(m_step == S_DONE || m_step == S_IDLE) && !(stop_lrt2 && m_step == S_LRT && m_rt == 2)
           && n < budget) begin
      drive();
      sample();
      if (chk_init && m_step == S_INIT) begin
        check("restart_init_ops", 32'(bus.router_op), 32'h1111);
        check("restart_rt_dst", 32'(bus.rt_dst), 32'd0);
        chk_init = 0;
      end
      if (chk_ls && m_step == S_LS && !bus.stall) begin
        check("ls_traffic_dequeue", 32'(bus.traffic_op), 32'h0707);
        check("ls_router_op", 32'(bus.router_op), 32'h3333);
      end
      if (stall_arm && m_step == S_P0) begin
        if (bus.stall) begin
          check("stall_ops_nop", 32'(bus.router_op), 32'h0);
          check("stall_in_cycle_hold", 32'(bus.in_cycle), stall_cyc);
        end else begin
          check("phase0_after_stall", 32'(bus.router_op), 32'h4444);
          check("stall_length", stall_cnt, 3);
          stall_arm = 0;
        end
      end
      if (abort_at_p1 > 0 && bus.abort) begin
        check("in_cycle_saturated", 32'(bus.in_cycle), 32'd255);
        abort_at_p1 = 0;
      end
      edge_step();
      n++;
    end
    if (n >= budget) begin
      total++; bad++;
      $display("FAIL run_timeout: got %0d cycles, expected fewer than %0d", n, budget);
    end
    run_len = n;
  endtask

  initial begin
    int s_init, s_ls, s_fill0;
    int s_lrt [NR];
    bus.start = 0; bus.abort = 0; bus.stall = 0; bus.max_cycle = '0;
    bus.rt_valid = '0; bus.fill_pending = '0; bus.inject_ok = '0;
    bus.router_done = '0; bus.traffic_empty = '0;
    rtv_mode = 11; fill_n = 2; fill_pat = 15; quiet_at = 0; stall_pct = 0; abort_pct = 0;
    abort_at_p1 = 0; chk_ls = 0; chk_init = 0; stall_arm = 0; rnd = 0;
    cnt_init = 0; cnt_ls = 0; cnt_fill0 = 0;
    for (int i = 0; i < NR; i++) cnt_lrt[i] = 0;
    rst_n = 1'b0;
    model_reset();
    sample();
    check("reset_router_op", 32'(bus.router_op), 32'h0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_finished", 32'(bus.finished), 32'd0);
    edge_step();
    rst_n = 1'b1;

    // budget of 3 with rt_valid 1011 and two fill cycles
    s_init = cnt_init; s_ls = cnt_ls; s_fill0 = cnt_fill0;
    for (int i = 0; i < NR; i++) s_lrt[i] = cnt_lrt[i];
    run(3, 100, 0);
    idle_inputs();
    sample();
    check("t1_finished", 32'(bus.finished), 32'd1);
    check("t1_reason", 32'(bus.done_reason), 32'd1);
    check("t1_in_cycle", 32'(bus.in_cycle), 32'd3);
    check("t1_run_len", run_len, 19);
    check("t1_init_cycles", cnt_init - s_init, 1);
    check("t1_lrt_r0", cnt_lrt[0] - s_lrt[0], 4);
    check("t1_lrt_r2", cnt_lrt[2] - s_lrt[2], 0);
    check("t1_lrt_r3", cnt_lrt[3] - s_lrt[3], 4);
    check("t1_fill_cycles", cnt_fill0 - s_fill0, 2);
    check("t1_ls_cycles", cnt_ls - s_ls, 3);
    // abort while DONE returns to IDLE and clears the reason
    bus.abort = 1'b1;
    edge_step();
    bus.abort = 1'b0;
    sample();
    check("abort_done_finished", 32'(bus.finished), 32'd0);
    check("abort_done_reason", 32'(bus.done_reason), 32'd0);
    edge_step();

    // unlimited budget, quiescent during the 5th PHASE1
    rtv_mode = -1; fill_n = 1; fill_pat = 5; quiet_at = 5;
    run(0, 200, 0);
    idle_inputs();
    sample();
    check("t2_reason", 32'(bus.done_reason), 32'd2);
    check("t2_in_cycle", 32'(bus.in_cycle), 32'd5);
    edge_step();

    // inject_ok 0101 during LOAD_STAGING
    quiet_at = 0; fill_n = 0; chk_ls = 1;
    run(2, 100, 0);
    chk_ls = 0;
    idle_inputs();
    sample();
    check("t3_reason", 32'(bus.done_reason), 32'd1);
    edge_step();

    // three-cycle stall in PHASE0
    stall_arm = 1;
    run(2, 100, 0);
    idle_inputs();
    sample();
    check("t4_in_cycle", 32'(bus.in_cycle), 32'd2);
    edge_step();

    // fill never drains: overflow after FILL_DEPTH cycles
    fill_n = 1000; fill_pat = 1;
    s_ls = cnt_ls; s_fill0 = cnt_fill0;
    run(0, 100, 0);
    idle_inputs();
    sample();
    check("t5_reason", 32'(bus.done_reason), 32'd3);
    check("t5_fill_cycles", cnt_fill0 - s_fill0, 8);
    check("t5_no_ls", cnt_ls - s_ls, 0);
    check("t5_fill_idx", 32'(bus.fill_idx), 32'd7);
    edge_step();

    // async reset in the middle of LOAD_RT at rt_dst 2
    fill_n = 2; fill_pat = 15;
    run(0, 100, 1);
    sample();
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_router_op", 32'(bus.router_op), 32'h0);
    check("rst_rt_dst", 32'(bus.rt_dst), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    edge_step();
    rst_n = 1'b1;
    chk_init = 1;
    run(1, 100, 0);
    idle_inputs();
    sample();
    check("t6_restart_reason", 32'(bus.done_reason), 32'd1);
    check("t6_restart_in_cycle", 32'(bus.in_cycle), 32'd1);
    edge_step();

    // unlimited run long enough to saturate in_cycle, ended by abort
    quiet_at = 0; fill_n = 0; abort_at_p1 = 258;
    run(0, 900, 0);
    abort_at_p1 = 0;
    idle_inputs();
    sample();
    check("sat_abort_idle", 32'(bus.busy), 32'd0);
    edge_step();

    // randomized runs
    for (int k = 0; k < 30; k++) begin
      rtv_mode = -1; fill_n = $urandom_range(0, 9); fill_pat = $urandom_range(1, 15);
      quiet_at = -1; stall_pct = 20; abort_pct = 2; rnd = 1;
      run($urandom_range(0, 6), 400, 0);
      idle_inputs();
      sample();
      edge_step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/noc_sequencer.md
Name: noc_sequencer

Overview:
Synthesizable NoC run controller, parametrised in router count, cycle-counter width and fill depth. Replaces the behavioural top-level sequencing loop. Drives per-router router_op and traffic_op codes through these steps in order: init, routing-table load, traffic init/fill, then repeated LoadStaging/Phase0/Phase1 simulation cycles. Terminates on a cycle budget or on global quiescence, reports status, and supports stall and abort.

Parameters:
NUM_ROUTERS, 16, number of routers/traffic generators driven
ROUTER_BITS, 4, width of router index (ceil log2 NUM_ROUTERS, min 1)
OP_BITS, 4, width of one op code
CYCLE_BITS, 16, width of in_cycle and max_cycle
FILL_DEPTH, 64, maximum packets filled per traffic generator
FILL_BITS, 6, width of fill_idx (ceil log2 FILL_DEPTH)

Ports:
clk  in  1  clock, all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begins a run from IDLE or DONE
abort  in  1  returns to IDLE next edge from any state
stall  in  1  freezes state and counters; all ops forced NOP while high
max_cycle  in  CYCLE_BITS  cycle budget; 0 = unlimited; sampled on start
rt_valid  in  NUM_ROUTERS  bit i: router i has a routing entry for rt_dst
fill_pending  in  NUM_ROUTERS  bit i: traffic i still has packets to fill
inject_ok  in  NUM_ROUTERS  bit i: router i can accept its head flit (can_inject at head VC)
router_done  in  NUM_ROUTERS  bit i: router i idle/drained
traffic_empty  in  NUM_ROUTERS  bit i: traffic queue i empty
router_op  out  NUM_ROUTERS*OP_BITS  op to router i at slice i
traffic_op  out  NUM_ROUTERS*OP_BITS  op to traffic i at slice i
rt_dst  out  ROUTER_BITS  destination index being loaded
fill_idx  out  FILL_BITS  packet index being filled
in_cycle  out  CYCLE_BITS  completed simulation cycles
busy  out  1  high in every state except IDLE and DONE
finished  out  1  high in DONE
done_reason  out  2  0 none, 1 budget, 2 quiescent, 3 fill overflow

Behaviour:
- Op encoding: NOP=0, Init=1, LoadRt=2, LoadStaging=3, Phase0=4, Phase1=5, Fill=6, Dequeue=7.
- States: IDLE, INIT, LOAD_RT, INIT_TRAFFIC, FILL, LOAD_STAGING, PHASE0, PHASE1, DONE.
- Outputs are Moore: decoded from the registered state and counters, no input-to-output paths except the stall, rt_valid, fill_pending and inject_ok gating below.
- Reset (async, rst_n=0): state IDLE, all ops NOP, rt_dst=0, fill_idx=0, in_cycle=0, busy=0, finished=0, done_reason=0.
- IDLE/DONE: all ops NOP. On start: go to INIT, latch max_cycle, clear counters and done_reason.
- INIT (1 cycle): router_op all Init; traffic_op all NOP.
- LOAD_RT (NUM_ROUTERS cycles): router_op[i] = LoadRt if rt_valid[i], else NOP. rt_dst increments each cycle. After rt_dst==NUM_ROUTERS-1, go to INIT_TRAFFIC. rt_dst does not wrap within a run.
- INIT_TRAFFIC (1 cycle): traffic_op all Init; router_op all NOP.
- FILL: traffic_op[i] = Fill if fill_pending[i], else NOP. fill_idx increments each cycle.
  - Exit to LOAD_STAGING when fill_pending==0. If fill_pending is 0 on entry, FILL lasts one all-NOP cycle.
  - If fill_idx==FILL_DEPTH-1 and fill_pending is still nonzero, go to DONE with done_reason=3.
- LOAD_STAGING: router_op all LoadStaging; traffic_op[i] = Dequeue if inject_ok[i], else NOP. Next state PHASE0.
- PHASE0: router_op all Phase0. Next state PHASE1.
- PHASE1: router_op all Phase1. in_cycle increments, saturating at all-ones. Next state is chosen in this priority order:
  1. DONE with reason 1 if max_cycle!=0 and in_cycle+1==max_cycle.
  2. DONE with reason 2 if router_done and traffic_empty are all ones.
  3. Otherwise LOAD_STAGING.
- stall=1: state and counters hold; every op slice is NOP. The same step re-issues once stall drops.
- Priority of simultaneous controls: abort > stall > start. abort in DONE or IDLE still gives IDLE, with done_reason cleared. start outside IDLE/DONE is ignored.
- Reset mid-run: immediate return to the reset values, with no partial ops issued.

Test Plan:
- NUM_ROUTERS=4, rt_valid=4'b1011, fill_pending cleared after 2 cycles, max_cycle=3, start -> 1 Init, 4 LoadRt cycles (router 2 NOP each), 1 INIT_TRAFFIC, 2 Fill cycles, then 3×(LoadStaging, Phase0, Phase1). finished=1, done_reason=1, in_cycle=3.
- max_cycle=0; router_done and traffic_empty driven all ones during the 5th PHASE1 -> DONE, done_reason=2, in_cycle=5.
- inject_ok=4'b0101 in LOAD_STAGING -> traffic_op slices 0 and 2 = Dequeue (7), slices 1 and 3 = NOP.
- stall held 3 cycles during PHASE0 -> ops NOP for 3 cycles, then Phase0 issued once; in_cycle unchanged during the stall.
- fill_pending stuck 4'b0001, FILL_DEPTH=8 -> 8 FILL cycles, then DONE with done_reason=3 and no LoadStaging ever issued.
- rst_n pulsed low during LOAD_RT at rt_dst=2 -> outputs return to reset values asynchronously. A subsequent start restarts at INIT with rt_dst=0.
